// File: rtl/dmem_request_pipe_pkg.sv
// Shared types and defaults for the data-memory request pipe.
package dmem_pkg;

   localparam int DEF_DEPTH       = 4;
   localparam int DEF_MEM_LATENCY = 3;
   localparam int DEF_WORDS       = 1024;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   typedef struct packed {
      logic        rw;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  id;
   } req_t;

endpackage

// File: rtl/dmem_request_pipe_if.sv
// Request/completion bus between the LSQ (master) and the request pipe (slave).
interface dmem_request_pipe_if;

   logic        valid_in;
   logic        rw_in;
   logic [31:0] addr_in;
   logic [31:0] data_in;
   logic [3:0]  id_in;
   logic [31:0] data_out;
   logic [3:0]  id_out;
   logic        ready_out;
   logic        stall_out;

   modport master (
      output valid_in, rw_in, addr_in, data_in, id_in,
      input  data_out, id_out, ready_out, stall_out
   );

   modport slave (
      input  valid_in, rw_in, addr_in, data_in, id_in,
      output data_out, id_out, ready_out, stall_out
   );

endinterface

// File: rtl/dmem_request_pipe_fifo.sv
// Request FIFO: power-of-two depth, head visible combinationally, pointers wrap.
module dmem_req_fifo
   import dmem_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  req_t                     push_req,
   input  logic                     pop,
   output req_t                     head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   req_t            store_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            push_ok;
   logic            pop_ok;

   // A full FIFO refuses pushes and an empty one refuses pops, whatever the caller does.
   assign push_ok = push && (count_q != CW'(DEPTH));
   assign pop_ok  = pop && (count_q != '0);

   // Next pointers and occupancy; simultaneous push and pop leave the count unchanged.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; storage contents need no reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage written at the tail.
   always_ff @(posedge clk) begin
      if (push_ok) store_q[wr_ptr_q] <= push_req;
   end

   assign head  = store_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/dmem_request_pipe.sv
// In-order data-memory request pipe: FIFO-buffered tagged loads/stores against a
// word-addressed array with a fixed access latency and one completion pulse each.
module dmem_request_pipe
   import dmem_pkg::*;
#(
   parameter int DEPTH       = DEF_DEPTH,
   parameter int MEM_LATENCY = DEF_MEM_LATENCY,
   parameter int WORDS       = DEF_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   dmem_request_pipe_if.slave bus
);

   localparam int IW   = $clog2(WORDS);
   localparam int CNTW = $clog2(MEM_LATENCY) + 1;
   localparam int CW   = $clog2(DEPTH) + 1;
   localparam logic [CNTW-1:0] LAT_M1 = CNTW'(MEM_LATENCY - 1);

   logic [31:0]     mem [WORDS];
   state_e          state_q;
   logic [CNTW-1:0] cnt_q;
   logic [31:0]     data_out_q;
   logic [3:0]      id_out_q;
   logic            ready_out_q;

   req_t            push_req;
   req_t            head;
   logic [CW-1:0]   count;
   logic            stall;
   logic            push;
   logic            done;
   logic [IW-1:0]   head_idx;
   logic            unused_addr_bits;

   assign stall    = (count == CW'(DEPTH));
   assign push     = bus.valid_in && !stall;
   assign done     = (state_q == ACCESS) && (cnt_q == '0);
   assign head_idx = head.addr[IW+1:2];

   // Byte offset and bits above the array size do not take part in addressing.
   assign unused_addr_bits = ^{head.addr[31:IW+2], head.addr[1:0]};

   assign push_req.rw   = bus.rw_in;
   assign push_req.addr = bus.addr_in;
   assign push_req.data = bus.data_in;
   assign push_req.id   = bus.id_in;

   dmem_req_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_req (push_req),
      .pop      (done),
      .head     (head),
      .count    (count)
   );

   // Access sequencer: wait out the latency on the head entry, then complete and pop it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         data_out_q  <= '0;
         id_out_q    <= '0;
         ready_out_q <= 1'b0;
      end else begin
         ready_out_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (count != '0) begin
                  state_q <= ACCESS;
                  cnt_q   <= LAT_M1;
               end
            end
            ACCESS: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end else begin
                  data_out_q  <= head.rw ? head.data : mem[head_idx];
                  id_out_q    <= head.id;
                  ready_out_q <= 1'b1;
                  // A push on this same edge is not counted yet, so only an entry
                  // already behind the head keeps the pipe in ACCESS.
                  if (count > CW'(1)) begin
                     cnt_q <= LAT_M1;
                  end else begin
                     state_q <= IDLE;
                     cnt_q   <= '0;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // Data array write on a store's completion edge; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (done && head.rw) mem[head_idx] <= head.data;
   end

   assign bus.data_out  = data_out_q;
   assign bus.id_out    = id_out_q;
   assign bus.ready_out = ready_out_q;
   assign bus.stall_out = stall;

endmodule

// File: doc/dmem_request_pipe.md
# dmem_request_pipe

In-order data-memory request pipe sitting directly downstream of the load/store queue in the MEM stage. Accepts tagged load/store requests from the LSQ, buffers them in a small FIFO, performs each access against a word-addressed 4 KB data array with a fixed programmable latency, and returns one tagged completion per request in issue order. Backpressure to the LSQ and pipeline goes through `stall_out`.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries (power of two, >= 2)
- MEM_LATENCY, 3, cycles a memory access occupies the array (>= 1)
- WORDS, 1024, data array size in 32-bit words (power of two)

Ports:
- clk  in  1  the block's single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- valid_in  in  1  request present on addr/data/rw/id this cycle
- rw_in  in  1  1 = store, 0 = load
- addr_in  in  32  byte address
- data_in  in  32  store data; ignored for loads
- id_in  in  4  LSQ entry id for the request
- data_out  out  32  load data, or echoed store data, valid while ready_out = 1
- id_out  out  4  id of the completing request, valid while ready_out = 1
- ready_out  out  1  one-cycle completion pulse for the oldest request
- stall_out  out  1  FIFO full; no request accepted this cycle

## Operation
- Accept: at a rising edge with valid_in = 1 and stall_out = 0, push {rw, addr, data, id}. valid_in while stall_out = 1 is ignored and not queued.
- stall_out = (count == DEPTH), combinational from the registered count.
- Index = addr_in[log2(WORDS)+1:2]; addr[1:0] and upper bits ignored. No alignment fault.
- FSM states: IDLE, ACCESS.
  - IDLE: if FIFO non-empty -> ACCESS, cnt <= MEM_LATENCY-1.
  - ACCESS, cnt != 0: cnt decrements.
  - ACCESS, cnt == 0, at the completion edge: store writes mem[index] <= data and data_out <= data; load sets data_out <= mem[index]. Also id_out <= head id, ready_out <= 1, pop head. Next state: ACCESS with cnt <= MEM_LATENCY-1 if the FIFO holds another entry after the pop, else IDLE.
- ready_out is low in every cycle not immediately after a completion edge. data_out and id_out hold their last values when ready_out is low.
- Push and pop on the same edge: count is unchanged and both take effect.
- A request pushed on the same edge the FIFO becomes empty is not visible until the next cycle, so IDLE is taken for one cycle.
- Strict in-order completion. A load after a store to the same index returns the stored value.
- Reset, asserted at any time:
  - FIFO emptied, state IDLE, cnt 0.
  - data_out 0, id_out 0, ready_out 0, stall_out 0.
  - Any in-flight store that has not reached its completion edge is discarded.
  - The data array is not reset.

## Timing
- A request accepted at edge T into an empty, idle pipe causes ready_out to be high during the cycle after edge T+1+MEM_LATENCY. That is MEM_LATENCY+1 cycles of latency.
- Sustained throughput with the FIFO non-empty: one completion every MEM_LATENCY cycles. With MEM_LATENCY = 1, that is one completion per cycle.
- Counter width: clog2(MEM_LATENCY)+1. FIFO count width: clog2(DEPTH)+1. Pointers wrap modulo DEPTH.

## Structure
- Shared package `dmem_pkg` holds:
  - state enum {IDLE, ACCESS}
  - request struct {rw, addr[31:0], data[31:0], id[3:0]}
  - default parameter constants
- One sub-module, `dmem_req_fifo`: a synchronous FIFO with parameterized DEPTH. It has push/pop, head output, count, and an active-low async reset that clears pointers and count.
- The data array and FSM live in the top module.

## Test plan
- Reset: drive rst low mid-ACCESS with 3 requests queued → all outputs 0 immediately. After release, no ready_out pulse until a new request is accepted.
- Single load, MEM_LATENCY = 3: store 0xDEADBEEF to 0x40 (id 1), then load 0x40 (id 2) → two pulses, 3 cycles apart:
  - id_out = 1 with data_out = 0xDEADBEEF
  - id_out = 2 with data_out = 0xDEADBEEF
  - The first pulse comes 4 cycles after the store is accepted.
- Full/backpressure, DEPTH = 4: issue 6 requests every cycle → stall_out rises after the 4th accept. Requests 5 and 6 are accepted only when stall_out is low, and all ids complete in issue order.
- Same-edge push/pop at full: hold valid_in while a completion occurs with count = 4 → no accept that edge. Accept on the next edge, with count staying at 4.
- Address aliasing: store 0x11 to 0x0000_1004, then load 0x0000_0007 → data_out = 0x11, since both map to index 1.
- Back-to-back, MEM_LATENCY = 1: 8 loads to distinct preloaded words → ready_out high for 8 consecutive cycles with the correct id/data pairs.
